// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller: register-address width,
// divider defaults and the divider scoreboard state type.
package pipeline_stall_controller_pkg;

  localparam int unsigned REGISTER_FILE_ADDRESS_WIDTH = 5;
  localparam int unsigned DIV_LATENCY_DEFAULT         = 8;
  // Wide enough for DIV_LATENCY-1 at the maximum legal latency of 64.
  localparam int unsigned DIV_CNT_WIDTH               = 6;

  typedef logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_e;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Decode-side hazard inputs and hold/flush/scoreboard outputs of the stall controller.
interface pipeline_stall_controller_if #(
  parameter int unsigned STALL_CNT_WIDTH = 32
);
  import pipeline_stall_controller_pkg::*;

  logic                       idex_ctrl_mem_r;
  reg_addr_t                  idex_rd;
  logic                       idex_div_valid;
  logic                       idex_branch_taken;
  reg_addr_t                  ifid_rs1;
  reg_addr_t                  ifid_rs2;
  reg_addr_t                  ifid_rd;
  logic                       ifid_is_div;

  logic                       pc_hold;
  logic                       ifid_hold;
  logic                       ctrl_hold;
  logic                       ifid_flush;
  logic                       idex_flush;
  logic                       div_busy;
  reg_addr_t                  div_rd;
  logic                       div_wb_en;
  logic                       div_overlap_err;
  logic [STALL_CNT_WIDTH-1:0] stall_cycles;

  modport master (
    output idex_ctrl_mem_r, idex_rd, idex_div_valid, idex_branch_taken,
           ifid_rs1, ifid_rs2, ifid_rd, ifid_is_div,
    input  pc_hold, ifid_hold, ctrl_hold, ifid_flush, idex_flush,
           div_busy, div_rd, div_wb_en, div_overlap_err, stall_cycles
  );

  modport slave (
    input  idex_ctrl_mem_r, idex_rd, idex_div_valid, idex_branch_taken,
           ifid_rs1, ifid_rs2, ifid_rd, ifid_is_div,
    output pc_hold, ifid_hold, ctrl_hold, ifid_flush, idex_flush,
           div_busy, div_rd, div_wb_en, div_overlap_err, stall_cycles
  );

endinterface

// File: rtl/pipeline_stall_controller_div_scoreboard.sv
// Tracks the single in-flight fixed-latency divide: busy window, destination
// register, write-back pulse and the sticky overlapping-issue error.
module pipeline_stall_controller_div_scoreboard
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      div_valid_i,
  input  logic      branch_taken_i,
  input  reg_addr_t issue_rd_i,
  output logic      div_busy_o,
  output reg_addr_t div_rd_o,
  output logic      div_wb_en_o,
  output logic      overlap_err_o
);

  div_state_e               state_q, state_d;
  logic [DIV_CNT_WIDTH-1:0] cnt_q, cnt_d;
  reg_addr_t                rd_q, rd_d;
  logic                     err_q, err_d;
  logic                     last_cycle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    last_cycle = (cnt_q == DIV_CNT_WIDTH'(1));
    // An issue attempt while busy is dropped; only the error is recorded.
    err_d      = err_q | (div_valid_i & (state_q == BUSY));
    case (state_q)
      IDLE: begin
        if (div_valid_i && !branch_taken_i) begin
          state_d = BUSY;
          cnt_d   = DIV_CNT_WIDTH'(DIV_LATENCY - 1);
          rd_d    = issue_rd_i;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - DIV_CNT_WIDTH'(1);
        if (last_cycle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_busy_o    = (state_q == BUSY);
    div_wb_en_o   = (state_q == BUSY) && (cnt_q == DIV_CNT_WIDTH'(1));
    div_rd_o      = rd_q;
    overlap_err_o = err_q;
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Decode-stage hold/flush sequencer: load-use and divider hazards produce holds,
// a taken branch flushes IF/ID and ID/EX, and held cycles are counted.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned DIV_LATENCY     = DIV_LATENCY_DEFAULT,
  parameter int unsigned STALL_CNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pipeline_stall_controller_if.slave  bus
);

  logic                       div_busy;
  reg_addr_t                  div_rd;
  logic                       div_wb_en;
  logic                       div_overlap_err;
  logic                       load_use, div_raw, div_struct, stall, hold;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  pipeline_stall_controller_div_scoreboard #(
    .DIV_LATENCY (DIV_LATENCY)
  ) u_div_scoreboard (
    .clk            (clk),
    .rst_n          (rst_n),
    .div_valid_i    (bus.idex_div_valid),
    .branch_taken_i (bus.idex_branch_taken),
    .issue_rd_i     (bus.idex_rd),
    .div_busy_o     (div_busy),
    .div_rd_o       (div_rd),
    .div_wb_en_o    (div_wb_en),
    .overlap_err_o  (div_overlap_err)
  );

  always_comb begin
    load_use   = bus.idex_ctrl_mem_r && (bus.idex_rd != '0) &&
                 ((bus.idex_rd == bus.ifid_rs1) || (bus.idex_rd == bus.ifid_rs2));
    // Destination match covers WAW against the in-flight divide.
    div_raw    = div_busy && (div_rd != '0) &&
                 ((div_rd == bus.ifid_rs1) || (div_rd == bus.ifid_rs2) ||
                  (div_rd == bus.ifid_rd));
    div_struct = div_busy && bus.ifid_is_div;
    stall      = load_use || div_raw || div_struct;
    hold       = stall && !bus.idex_branch_taken;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.pc_hold         = hold;
  assign bus.ifid_hold       = hold;
  assign bus.ctrl_hold       = hold;
  assign bus.ifid_flush      = bus.idex_branch_taken;
  assign bus.idex_flush      = bus.idex_branch_taken;
  assign bus.div_busy        = div_busy;
  assign bus.div_rd          = div_rd;
  assign bus.div_wb_en       = div_wb_en;
  assign bus.div_overlap_err = div_overlap_err;
  assign bus.stall_cycles    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: vector table, directed divider/flush/reset sequences and
// randomized traffic compared against a cycle-window reference model.
module tb_pipeline_stall_controller;
  import pipeline_stall_controller_pkg::*;

  localparam int unsigned L = 8;
  localparam int          W = REGISTER_FILE_ADDRESS_WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_stall_controller_if #(.STALL_CNT_WIDTH(32)) bus ();
  pipeline_stall_controller_if #(.STALL_CNT_WIDTH(3))  sbus ();

  assign sbus.idex_ctrl_mem_r   = bus.idex_ctrl_mem_r;
  assign sbus.idex_rd           = bus.idex_rd;
  assign sbus.idex_div_valid    = bus.idex_div_valid;
  assign sbus.idex_branch_taken = bus.idex_branch_taken;
  assign sbus.ifid_rs1          = bus.ifid_rs1;
  assign sbus.ifid_rs2          = bus.ifid_rs2;
  assign sbus.ifid_rd           = bus.ifid_rd;
  assign sbus.ifid_is_div       = bus.ifid_is_div;

  pipeline_stall_controller #(.DIV_LATENCY(L), .STALL_CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  pipeline_stall_controller #(.DIV_LATENCY(L), .STALL_CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sbus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a divide issued at cycle `issue` is busy in cycles
  // issue+1 .. issue+L-1 and writes back in the last of those.
  int          cyc   = 0;
  int          issue = -1;
  logic [W-1:0] m_rd = '0;
  bit          m_err = 1'b0;
  longint      m_st  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic memr, input logic [W-1:0] idrd,
                      input logic divv, input logic br, input logic [W-1:0] rs1,
                      input logic [W-1:0] rs2, input logic [W-1:0] ifrd, input logic isdiv);
    bit busy, wb, lu, raw, hold;
    @(negedge clk);
    rst_n                 = rst;
    bus.idex_ctrl_mem_r   = memr;
    bus.idex_rd           = idrd;
    bus.idex_div_valid    = divv;
    bus.idex_branch_taken = br;
    bus.ifid_rs1          = rs1;
    bus.ifid_rs2          = rs2;
    bus.ifid_rd           = ifrd;
    bus.ifid_is_div       = isdiv;
    #1;
    busy = (issue >= 0) && (cyc > issue) && (cyc <= issue + int'(L) - 1);
    wb   = busy && (cyc == issue + int'(L) - 1);
    lu   = memr && (idrd != 0) && ((idrd == rs1) || (idrd == rs2));
    raw  = busy && (m_rd != 0) && ((m_rd == rs1) || (m_rd == rs2) || (m_rd == ifrd));
    hold = (lu || raw || (busy && isdiv)) && !br;
    chk("pc_hold",    bus.pc_hold,    hold);
    chk("ifid_hold",  bus.ifid_hold,  hold);
    chk("ctrl_hold",  bus.ctrl_hold,  hold);
    chk("ifid_flush", bus.ifid_flush, br);
    chk("idex_flush", bus.idex_flush, br);
    chk("div_busy",   bus.div_busy,   busy);
    chk("div_wb_en",  bus.div_wb_en,  wb);
    chk("overlap_err", bus.div_overlap_err, m_err);
    chk("stall_cycles", bus.stall_cycles, m_st);
    chk("stall_sat",  sbus.stall_cycles, (m_st > 7) ? 7 : m_st);
    if (busy) chk("div_rd", bus.div_rd, m_rd);
    if (!rst) begin
      issue = -1; m_rd = '0; m_err = 1'b0; m_st = 0;
    end else begin
      if (divv && busy) m_err = 1'b1;
      else if (divv && !br) begin issue = cyc; m_rd = idrd; end
      if (hold && m_st != 64'hFFFF_FFFF) m_st++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic memr; logic [W-1:0] idrd; logic br; logic [W-1:0] rs1; logic [W-1:0] rs2;
    logic exp_hold; logic exp_flush;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int nb, nh, wb_at, last_h, rdbad, anywb;
    bus.idex_ctrl_mem_r = 0; bus.idex_rd = 0; bus.idex_div_valid = 0;
    bus.idex_branch_taken = 0; bus.ifid_rs1 = 0; bus.ifid_rs2 = 0;
    bus.ifid_rd = 0; bus.ifid_is_div = 0;

    vecs[0] = '{1, 5, 0, 5, 0, 1, 0};
    vecs[1] = '{1, 5, 0, 0, 5, 1, 0};
    vecs[2] = '{1, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{1, 5, 0, 6, 7, 0, 0};
    vecs[4] = '{0, 5, 0, 5, 5, 0, 0};
    vecs[5] = '{1, 5, 1, 5, 0, 0, 1};
    vecs[6] = '{0, 0, 1, 0, 0, 0, 1};
    vecs[7] = '{1, 31, 0, 3, 31, 1, 0};

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single load-use on x5 holds exactly one cycle.
    step(1, 1, 5, 0, 0, 5, 0, 0, 0);
    chk("lu_hold", bus.pc_hold, 1);
    step(1, 0, 0, 0, 0, 5, 0, 0, 0);
    chk("lu_release", bus.pc_hold, 0);
    chk("lu_count", bus.stall_cycles, 1);

    foreach (vecs[i]) begin
      step(1, vecs[i].memr, vecs[i].idrd, 0, vecs[i].br, vecs[i].rs1, vecs[i].rs2, 0, 0);
      chk("vec_hold",  bus.ctrl_hold,  vecs[i].exp_hold);
      chk("vec_flush", bus.idex_flush, vecs[i].exp_flush);
    end

    // Divide to x7 with an independent reader of x3.
    step(1, 0, 7, 1, 0, 0, 0, 0, 0);
    nb = 0; nh = 0; wb_at = 0; rdbad = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 0, 0, 0, 3, 0, 0, 0);
      if (bus.div_busy) begin nb++; if (bus.div_rd != 7) rdbad++; end
      if (bus.div_wb_en) wb_at = i;
      if (bus.pc_hold) nh++;
    end
    chk("div_busy_len", nb, 7);
    chk("div_wb_at", wb_at, 7);
    chk("div_rd_bad", rdbad, 0);
    chk("indep_holds", nh, 0);

    // Dependent reader of x7 is held through write-back.
    step(1, 0, 7, 1, 0, 7, 0, 0, 0);
    nh = 0; last_h = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 0, 0, 0, 7, 0, 0, 0);
      if (bus.pc_hold) begin nh++; last_h = i; end
    end
    chk("raw_holds", nh, 7);
    chk("raw_last_hold", last_h, 7);

    // Structural hold on a second divide, plus an overlapping issue attempt.
    step(1, 0, 9, 1, 0, 0, 0, 0, 0);
    nh = 0; wb_at = 0; rdbad = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 12, (i == 3), 0, 1, 2, 3, 1);
      if (bus.pc_hold) nh++;
      if (bus.div_wb_en) wb_at = i;
      if (bus.div_busy && bus.div_rd != 9) rdbad++;
    end
    chk("struct_holds", nh, 7);
    chk("overlap_wb_at", wb_at, 7);
    chk("overlap_rd_bad", rdbad, 0);
    idle(3);
    chk("overlap_sticky", bus.div_overlap_err, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("overlap_cleared", bus.div_overlap_err, 0);

    // Branch flush beats a load-use hold; in-flight divide still completes.
    step(1, 0, 7, 1, 0, 0, 0, 0, 0);
    step(1, 1, 5, 0, 1, 5, 0, 7, 0);
    chk("br_ifid_flush", bus.ifid_flush, 1);
    chk("br_hold", bus.pc_hold, 0);
    wb_at = 1;
    for (int i = 2; i <= 10; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      if (bus.div_wb_en) wb_at = i;
    end
    chk("br_div_wb_at", wb_at, 7);

    // Divide issued together with a taken branch never starts.
    step(1, 0, 7, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 7, 0, 0, 0);
    chk("br_div_not_started", bus.div_busy, 0);

    // Reset on busy cycle 3 abandons the divide.
    step(1, 1, 4, 0, 0, 4, 0, 0, 0);
    step(1, 0, 7, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_busy_before", bus.div_busy, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_busy", bus.div_busy, 0);
    chk("rst_rd", bus.div_rd, 0);
    chk("rst_stalls", bus.stall_cycles, 0);
    anywb = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      if (bus.div_wb_en) anywb++;
    end
    chk("rst_no_wb", anywb, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) == 0),
           W'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), W'($urandom_range(0, 7)),
           W'($urandom_range(0, 7)), W'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
